// File: rtl/hilo_unit.sv
// hilo_unit: HI/LO register pair with a 32-step restoring divider; HI/LO write forwarding to EXE
// is compiled in when HILO_FWD_EN is defined.
module hilo_unit #(
   parameter int WIDTH_REG  = 32,
   parameter int DIV_CYCLES = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   mem_i_hilowe,
   input  logic [2*WIDTH_REG-1:0] mem_i_mulres,
   input  logic                   wb_i_hilowe,
   input  logic [2*WIDTH_REG-1:0] wb_i_mulres,
   input  logic                   div_i_start,
   input  logic                   div_i_signed,
   input  logic [WIDTH_REG-1:0]   div_i_dividend,
   input  logic [WIDTH_REG-1:0]   div_i_divisor,
   output logic                   div_o_busy,
   output logic                   div_o_done,
   output logic [WIDTH_REG-1:0]   hi_o,
   output logic [WIDTH_REG-1:0]   lo_o
);
   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV_CYCLES - 1);
   typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
   state_t state, state_nx;
   logic [WIDTH_REG-1:0] hi_q, lo_q, quo_q, dvs_q, abs_a, abs_b, quo_fix, rem_fix;
   logic [WIDTH_REG:0]   rem_q, shifted;
   logic [WIDTH_REG+1:0] diff;
   logic [CW-1:0]        cnt_q;
   logic                 sign_q, sign_r, zero_q, neg;
   assign abs_a   = (div_i_signed && div_i_dividend[WIDTH_REG-1]) ? -div_i_dividend : div_i_dividend;
   assign abs_b   = (div_i_signed && div_i_divisor[WIDTH_REG-1]) ? -div_i_divisor : div_i_divisor;
   assign shifted = {rem_q[WIDTH_REG-1:0], quo_q[WIDTH_REG-1]};
   assign diff    = {1'b0, shifted} - {2'b0, dvs_q};
   assign neg     = diff[WIDTH_REG+1];
   // Divide-by-zero keeps the raw unsigned quotient; remainder fix restores the original dividend
   assign quo_fix = (sign_q && !zero_q) ? -quo_q : quo_q;
   assign rem_fix = sign_r ? -rem_q[WIDTH_REG-1:0] : rem_q[WIDTH_REG-1:0];
   assign div_o_busy = (state != IDLE);
   assign div_o_done = (state == FIX);
   always_comb begin
      state_nx = state;
      state_nx = (state == IDLE && div_i_start) ? CALC :
                 (state == CALC && cnt_q == LAST) ? FIX :
                 (state == FIX) ? IDLE : state;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         quo_q  <= '0;
         dvs_q  <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         sign_q <= 1'b0;
         sign_r <= 1'b0;
         zero_q <= 1'b0;
      end else if (state == IDLE && div_i_start) begin
         quo_q  <= abs_a;
         dvs_q  <= abs_b;
         rem_q  <= '0;
         cnt_q  <= '0;
         sign_q <= div_i_signed & (div_i_dividend[WIDTH_REG-1] ^ div_i_divisor[WIDTH_REG-1]);
         sign_r <= div_i_signed & div_i_dividend[WIDTH_REG-1];
         zero_q <= (div_i_divisor == '0);
      end else if (state == CALC) begin
         rem_q <= neg ? shifted : diff[WIDTH_REG:0];
         quo_q <= {quo_q[WIDTH_REG-2:0], ~neg};
         cnt_q <= cnt_q + 1'b1;
      end
   end
   // Divider commit takes precedence over a coincident WB write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hi_q <= '0;
         lo_q <= '0;
      end else if (state == FIX) begin
         hi_q <= rem_fix;
         lo_q <= quo_fix;
      end else if (wb_i_hilowe) begin
         hi_q <= wb_i_mulres[2*WIDTH_REG-1:WIDTH_REG];
         lo_q <= wb_i_mulres[WIDTH_REG-1:0];
      end
   end
`ifdef HILO_FWD_EN
   assign hi_o = mem_i_hilowe ? mem_i_mulres[2*WIDTH_REG-1:WIDTH_REG] :
                 wb_i_hilowe  ? wb_i_mulres[2*WIDTH_REG-1:WIDTH_REG] : hi_q;
   assign lo_o = mem_i_hilowe ? mem_i_mulres[WIDTH_REG-1:0] :
                 wb_i_hilowe  ? wb_i_mulres[WIDTH_REG-1:0] : lo_q;
`else
   logic unused_fwd;
   assign unused_fwd = mem_i_hilowe ^ (^mem_i_mulres);
   assign hi_o = hi_q;
   assign lo_o = lo_q;
`endif
endmodule

// File: tb/tb_hilo_unit.sv
// tb_hilo_unit: table-driven and randomized checks of hilo_unit against a behavioural model.
module tb_hilo_unit;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        mem_i_hilowe = 1'b0, wb_i_hilowe = 1'b0;
   logic [63:0] mem_i_mulres = '0, wb_i_mulres = '0;
   logic        div_i_start = 1'b0, div_i_signed = 1'b0;
   logic [31:0] div_i_dividend = '0, div_i_divisor = '0;
   logic        div_o_busy, div_o_done;
   logic [31:0] hi_o, lo_o;
   int          checks = 0, errors = 0;
   logic [31:0] m_hi = '0, m_lo = '0;
   typedef struct {
      logic [31:0] a, b;
      logic        s;
      logic [31:0] hi, lo;
      logic        extra;
   } vec_t;
   vec_t tbl[7];
   hilo_unit dut (
      .clk(clk), .rst_n(rst_n),
      .mem_i_hilowe(mem_i_hilowe), .mem_i_mulres(mem_i_mulres),
      .wb_i_hilowe(wb_i_hilowe), .wb_i_mulres(wb_i_mulres),
      .div_i_start(div_i_start), .div_i_signed(div_i_signed),
      .div_i_dividend(div_i_dividend), .div_i_divisor(div_i_divisor),
      .div_o_busy(div_o_busy), .div_o_done(div_o_done),
      .hi_o(hi_o), .lo_o(lo_o)
   );
   always #5 clk = ~clk;
   always @(posedge clk)
      if (rst_n && div_o_done && wb_i_hilowe) begin
         errors++;
         $display("FAIL commit_wb_collision done=%0b wb=%0b required no overlap", div_o_done, wb_i_hilowe);
      end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
      longint sa, sb, q, r;
      if (b == 0) return {a, 32'hFFFF_FFFF};
      if (!s) return {a % b, a / b};
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
   endfunction
   function automatic logic [63:0] exp_out();
`ifdef HILO_FWD_EN
      if (mem_i_hilowe) return mem_i_mulres;
      if (wb_i_hilowe) return wb_i_mulres;
`endif
      return {m_hi, m_lo};
   endfunction
   task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic extra);
      int k, bc;
      @(posedge clk); #1;
      div_i_dividend = a; div_i_divisor = b; div_i_signed = s; div_i_start = 1'b1;
      @(posedge clk); #1;
      div_i_start = 1'b0;
      chk("busy_after_start", {31'b0, div_o_busy}, 32'd1);
      k = 0; bc = 1;
      for (int i = 1; i <= 40; i++) begin
         if (extra && i == 10) begin
            div_i_start = 1'b1; div_i_dividend = 32'd1000; div_i_divisor = 32'd3; div_i_signed = 1'b0;
         end
         if (extra && i == 11) div_i_start = 1'b0;
         @(posedge clk); #1;
         if (div_o_busy) bc++;
         if (div_o_done) begin k = i; break; end
      end
      chk("done_latency", k, 32'd32);
      chk("busy_cycles", bc, 32'd33);
      m_hi = ehi; m_lo = elo;
      @(posedge clk); #1;
      chk("busy_after_commit", {31'b0, div_o_busy}, 32'd0);
      chk("done_one_pulse", {31'b0, div_o_done}, 32'd0);
      chk("div_hi", hi_o, ehi);
      chk("div_lo", lo_o, elo);
   endtask
   initial begin
      logic [63:0] e;
      tbl[0] = '{32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0};
      tbl[1] = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
      tbl[2] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 1'b0};
      tbl[3] = '{32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFF_FFFF, 1'b1};
      tbl[4] = '{32'hFFFF_FFFB, 32'd0, 1'b1, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b0};
      tbl[5] = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'd1, 32'hFFFF_FFFD, 1'b0};
      tbl[6] = '{32'hFFFF_FFFF, 32'd16, 1'b0, 32'd15, 32'h0FFF_FFFF, 1'b0};
      repeat (2) @(posedge clk);
      #1;
      chk("reset_hi", hi_o, 32'd0);
      chk("reset_lo", lo_o, 32'd0);
      chk("reset_busy", {31'b0, div_o_busy}, 32'd0);
      chk("reset_done", {31'b0, div_o_done}, 32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      wb_i_hilowe = 1'b1; wb_i_mulres = 64'h0000_0001_0000_0002;
      @(posedge clk); #1;
      wb_i_hilowe = 1'b0; m_hi = 32'd1; m_lo = 32'd2;
      chk("wb_write_hi", hi_o, 32'd1);
      chk("wb_write_lo", lo_o, 32'd2);
`ifdef HILO_FWD_EN
      mem_i_hilowe = 1'b1; mem_i_mulres = 64'hAAAA_0000_5555_FFFF;
      wb_i_hilowe = 1'b1; wb_i_mulres = 64'h0000_0001_0000_0001;
      #1;
      chk("fwd_mem_hi", hi_o, 32'hAAAA_0000);
      chk("fwd_mem_lo", lo_o, 32'h5555_FFFF);
      mem_i_hilowe = 1'b0;
      #1;
      chk("fwd_wb_hi", hi_o, 32'd1);
      chk("fwd_wb_lo", lo_o, 32'd1);
      wb_i_hilowe = 1'b0;
`endif
      for (int i = 0; i < 7; i++) do_div(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].hi, tbl[i].lo, tbl[i].extra);
      @(posedge clk); #1;
      div_i_dividend = 32'h1234; div_i_divisor = 32'd7; div_i_signed = 1'b0; div_i_start = 1'b1;
      @(posedge clk); #1;
      div_i_start = 1'b0;
      repeat (14) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      m_hi = '0; m_lo = '0;
      chk("midreset_busy", {31'b0, div_o_busy}, 32'd0);
      chk("midreset_hi", hi_o, 32'd0);
      chk("midreset_lo", lo_o, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      do_div(32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0);
      for (int i = 0; i < 40; i++) begin
         mem_i_hilowe = ($urandom_range(0, 2) == 0);
         mem_i_mulres = {$urandom, $urandom};
         wb_i_hilowe = $urandom_range(0, 1) != 0;
         wb_i_mulres = {$urandom, $urandom};
         #1;
         e = exp_out();
         chk("rand_hi", hi_o, e[63:32]);
         chk("rand_lo", lo_o, e[31:0]);
         @(posedge clk);
         if (wb_i_hilowe) begin m_hi = wb_i_mulres[63:32]; m_lo = wb_i_mulres[31:0]; end
         #1;
      end
      mem_i_hilowe = 1'b0; wb_i_hilowe = 1'b0;
      for (int i = 0; i < 12; i++) begin
         logic [31:0] a, b;
         logic s;
         a = $urandom;
         b = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom_range(0, 1) ? $urandom : $urandom_range(1, 300));
         s = $urandom_range(0, 1) != 0;
         e = ref_div(a, b, s);
         do_div(a, b, s, e[63:32], e[31:0], 1'b0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/hilo_unit.md
Name: hilo_unit

Overview:
- Owns the HI/LO register pair that the EXE stage reads through hi_o/lo_o.
- Write side: takes the 64-bit mulres/hilowe pair the pipeline carries to the WB stage.
- Forwards in-flight MEM/WB HI/LO writes back to EXE.
- Contains a 32-iteration sequential divider (DIV/DIVU) that writes HI=remainder, LO=quotient and stalls the pipeline while busy.

Parameters:
WIDTH_REG, 32, width of HI, LO and divider operands
DIV_CYCLES, 32, iterations in CALC state; must equal WIDTH_REG

Ports:
clk  input  1  core clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
mem_i_hilowe  input  1  MEM-stage instruction writes HI/LO
mem_i_mulres  input  2*WIDTH_REG  MEM-stage HI/LO value {HI,LO}
wb_i_hilowe  input  1  WB-stage HI/LO write enable
wb_i_mulres  input  2*WIDTH_REG  WB-stage write data {HI,LO}
div_i_start  input  1  launch division, sampled only in IDLE
div_i_signed  input  1  1=DIV, 0=DIVU
div_i_dividend  input  WIDTH_REG  dividend
div_i_divisor  input  WIDTH_REG  divisor
div_o_busy  output  1  stall request to pipeline control
div_o_done  output  1  one-cycle pulse when result is committed
hi_o  output  WIDTH_REG  HI value to EXE
lo_o  output  WIDTH_REG  LO value to EXE

Behaviour:
- Reset (async, rst_n=0): HI=0, LO=0, state=IDLE, div_o_busy=0, div_o_done=0. hi_o/lo_o read 0 unless forwarding sources are active.
- Architectural write: on a clk edge with wb_i_hilowe=1, HI<=wb_i_mulres[63:32] and LO<=wb_i_mulres[31:0].
- Read, priority high to low:
  - mem_i_hilowe=1: mem_i_mulres halves.
  - else wb_i_hilowe=1: wb_i_mulres halves.
  - else: HI/LO registers.
  - Fully combinational, zero latency.
- Divider FSM, states IDLE -> CALC -> FIX -> IDLE:
  - IDLE:
    - div_i_start=1: latch |dividend| and |divisor| (absolute values only when div_i_signed=1).
    - Latch sign_q = dividend[31]^divisor[31] and sign_r = dividend[31], both forced 0 for DIVU.
    - Clear remainder accumulator, load iteration counter=0, go CALC.
  - CALC: one restoring shift-subtract step per cycle. After counter reaches DIV_CYCLES-1, go FIX.
  - FIX:
    - Negate quotient if sign_q; negate remainder if sign_r.
    - Commit HI<=remainder, LO<=quotient at the edge ending FIX.
    - div_o_done=1 for the FIX cycle only. Return to IDLE.
- Latency: start sampled at edge t. CALC covers cycles t+1..t+32, FIX is cycle t+33, HI/LO are visible from t+34.
- div_o_busy=1 in CALC and FIX, registered from state.
- div_i_start in CALC/FIX: ignored.
- Divisor=0: the FSM still runs the full sequence. Result is HI=dividend and LO=all-ones (unsigned iteration result, no sign fix). No exception is raised.
- Signed overflow (0x80000000 / 0xFFFFFFFF): LO=0x80000000, HI=0.
- Commit in the same edge as wb_i_hilowe: divider commit wins; the WB write is dropped. Pipeline control must not allow this; verification flags it as an assertion.
- Reset mid-division: FSM returns to IDLE immediately and HI/LO clear. There is no partial commit.

Optional Feature:
HILO_FWD_EN
- Defined: MEM/WB forwarding mux as described.
- Undefined: hi_o/lo_o are driven by the HI/LO registers only. Pipeline control must stall MFHI/MFLO until no HI/LO write is in flight. The divider is unaffected.

Test Plan:
1. Reset then wb_i_hilowe=1, wb_i_mulres=0x00000001_00000002 -> next cycle hi_o=0x1, lo_o=0x2.
2. Forwarding (HILO_FWD_EN defined): mem_i_hilowe=1 mulres=0xAAAA0000_5555FFFF, with wb_i_hilowe=1 mulres=0x1_1 in the same cycle -> hi_o=0xAAAA0000, lo_o=0x5555FFFF combinationally.
3. DIVU 100/7 -> busy for 33 cycles, done pulse at t+33, then hi_o=2, lo_o=14.
4. DIV -7/2 (0xFFFFFFF9, 2) -> LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). Also DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
5. DIVU 5/0 -> HI=5, LO=0xFFFFFFFF after the full 34-cycle sequence. A second start pulsed at cycle t+10 is ignored.
6. Assert rst_n=0 at cycle t+15 of a division -> busy=0, HI=LO=0 immediately. After release, a new DIVU 9/3 yields HI=0, LO=3.
